// File: rtl/transpose_pkg.sv
// Shared defaults and element type for the ping-pong transpose buffer.
package transpose_pkg;

    localparam int unsigned DEF_N = 8;
    localparam int unsigned DEF_W = 12;

    typedef logic [DEF_W-1:0] elem_t;

endpackage

// File: rtl/transpose_dbuf_tbank.sv
// One N x N storage bank: row-wide write port, row or column read mux.
module tbank
    import transpose_pkg::*;
#(
    parameter int unsigned N  = DEF_N,
    parameter int unsigned W  = DEF_W,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [IW-1:0]   wr_idx,
    input  logic [N*W-1:0]  wr_row,
    input  logic [IW-1:0]   rd_idx,
    input  logic            col_mode,
    output logic [N*W-1:0]  rd_vec_c
);

    logic [W-1:0] mem [N][N];

    // Storage is deliberately not reset; validity is tracked by the owner.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int c = 0; c < N; c++) begin
                mem[wr_idx][c] <= wr_row[c*W +: W];
            end
        end
    end

    always_comb begin
        rd_vec_c = '0;
        for (int e = 0; e < N; e++) begin
            rd_vec_c[e*W +: W] = col_mode ? mem[e][rd_idx] : mem[rd_idx][e];
        end
    end

endmodule

// File: rtl/transpose_dbuf.sv
// Two-bank ping-pong buffer: rows in, rows or columns out, one per cycle.
module transpose_dbuf
    import transpose_pkg::*;
#(
    parameter int unsigned N = DEF_N,
    parameter int unsigned W = DEF_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*W-1:0]  in_row,
    input  logic            in_clr,
    input  logic            mode,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N*W-1:0]  out_vec,
    output logic [1:0]      level
);

    localparam int unsigned IW   = $clog2(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    logic [IW-1:0] wr_cnt_q, wr_cnt_d;
    logic [IW-1:0] rd_cnt_q, rd_cnt_d;
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic [1:0]    full_q, full_d;
    logic [1:0]    mode_q, mode_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic [1:0]    level_q, level_d;

    logic          acc;
    logic          fire_out;
    logic [1:0]    bank_we;
    logic [N*W-1:0] bank_vec [2];

    // A row that coincides with in_clr is handshaken but dropped.
    assign acc      = in_valid & in_ready_q & ~in_clr;
    assign fire_out = out_valid_q & out_ready;

    always_comb begin
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        full_d    = full_q;
        mode_d    = mode_q;

        if (in_clr) begin
            wr_cnt_d = '0;
        end else if (acc) begin
            if (wr_cnt_q == '0) begin
                mode_d[wr_bank_q] = mode;
            end
            if (wr_cnt_q == LAST) begin
                wr_cnt_d          = '0;
                wr_bank_d         = ~wr_bank_q;
                full_d[wr_bank_q] = 1'b1;
            end else begin
                wr_cnt_d = wr_cnt_q + IW'(1);
            end
        end

        // Fill and release always target different banks, so both apply.
        if (fire_out) begin
            if (rd_cnt_q == LAST) begin
                rd_cnt_d          = '0;
                rd_bank_d         = ~rd_bank_q;
                full_d[rd_bank_q] = 1'b0;
            end else begin
                rd_cnt_d = rd_cnt_q + IW'(1);
            end
        end

        in_ready_d  = ~full_d[wr_bank_d];
        out_valid_d = full_d[rd_bank_d];
        level_d     = 2'(full_d[0]) + 2'(full_d[1]);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            full_q      <= '0;
            mode_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            level_q     <= '0;
        end else begin
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            full_q      <= full_d;
            mode_q      <= mode_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            level_q     <= level_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign bank_we[b] = acc & (wr_bank_q == 1'(b));

        tbank #(
            .N  (N),
            .W  (W),
            .IW (IW)
        ) u_bank (
            .clk      (clk),
            .we       (bank_we[b]),
            .wr_idx   (wr_cnt_q),
            .wr_row   (in_row),
            .rd_idx   (rd_cnt_q),
            .col_mode (mode_q[b]),
            .rd_vec_c (bank_vec[b])
        );
    end

    // Reading bank is full and never written, so out_vec holds under backpressure.
    assign out_vec   = rd_bank_q ? bank_vec[1] : bank_vec[0];
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign level     = level_q;

endmodule

// File: tb/tb_transpose_dbuf.sv
// Directed bench for transpose_dbuf with N=8, W=12.
module tb_transpose_dbuf;
    import transpose_pkg::*;

    localparam int N  = 8;
    localparam int W  = 12;
    localparam int VW = N * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [VW-1:0] in_row;
    logic          in_clr;
    logic          mode;
    logic          out_valid;
    logic          out_ready;
    logic [VW-1:0] out_vec;
    logic [1:0]    level;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    transpose_dbuf #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_row    (in_row),
        .in_clr    (in_clr),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_vec   (out_vec),
        .level     (level)
    );

    // Element (r,c) of block b is 256*b + 16*r + c.
    function automatic elem_t val(input int b, input int r, input int c);
        return elem_t'(256 * b + 16 * r + c);
    endfunction

    // tr=1: column k of block b; tr=0: row k of block b.
    function automatic logic [VW-1:0] vec(input int b, input bit tr, input int k);
        logic [VW-1:0] v;
        v = '0;
        for (int e = 0; e < N; e++) begin
            v[e*W +: W] = tr ? val(b, e, k) : val(b, k, e);
        end
        return v;
    endfunction

    task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [VW-1:0] row, input logic clr,
                         input logic md, input logic ordy);
        in_valid  = v;
        in_row    = row;
        in_clr    = clr;
        mode      = md;
        out_ready = ordy;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        chk("rst_ovld",  VW'(out_valid), VW'(0));
        chk("rst_irdy",  VW'(in_ready),  VW'(1));
        chk("rst_level", VW'(level),     VW'(0));
        rst = 1'b1;

        // Single block, transpose, consumer always ready.
        for (int t = 0; t < 16; t++) begin
            chk("A_ovld", VW'(out_valid), VW'(t >= 8));
            chk("A_irdy", VW'(in_ready),  VW'(1));
            if (t >= 8) chk("A_vec", out_vec, vec(0, 1'b1, t - 8));
            if (t == 11) begin
                chk("A_v3_e7", VW'(out_vec[95:84]), VW'(12'h073));
                chk("A_v3_e0", VW'(out_vec[11:0]),  VW'(12'h003));
            end
            drive(t < 8, (t < 8) ? vec(0, 1'b0, t) : '0, 1'b0, 1'b1, 1'b1);
            step();
        end
        chk("A_end_ovld", VW'(out_valid), VW'(0));

        // Same block, pass-through.
        for (int t = 0; t < 16; t++) begin
            chk("B_ovld", VW'(out_valid), VW'(t >= 8));
            if (t >= 8) chk("B_vec", out_vec, vec(0, 1'b0, t - 8));
            if (t == 11) begin
                chk("B_v3_e0", VW'(out_vec[11:0]),  VW'(12'h030));
                chk("B_v3_e7", VW'(out_vec[95:84]), VW'(12'h037));
            end
            drive(t < 8, (t < 8) ? vec(0, 1'b0, t) : '0, 1'b0, 1'b0, 1'b1);
            step();
        end

        // Two blocks back-to-back: no bubbles, level stays at 1.
        for (int t = 0; t < 24; t++) begin
            chk("C_irdy",  VW'(in_ready),  VW'(1));
            chk("C_level", VW'(level),     VW'(t >= 8 && t < 24));
            chk("C_ovld",  VW'(out_valid), VW'(t >= 8));
            if (t >= 8) chk("C_vec", out_vec, vec(2 + (t - 8) / 8, 1'b1, (t - 8) % 8));
            drive(t < 16, (t < 16) ? vec(2 + t / 8, 1'b0, t % 8) : '0, 1'b0, 1'b1, 1'b1);
            step();
        end
        chk("C_end_ovld", VW'(out_valid), VW'(0));

        // Backpressure: both banks fill; mode toggles mid-block are ignored.
        for (int t = 0; t < 16; t++) begin
            chk("D_irdy",  VW'(in_ready),  VW'(1));
            chk("D_level", VW'(level),     VW'(t >= 8));
            chk("D_ovld",  VW'(out_valid), VW'(t >= 8));
            if (t >= 8) chk("D_hold", out_vec, vec(4, 1'b1, 0));
            drive(1'b1, vec(4 + t / 8, 1'b0, t % 8), 1'b0,
                  (t < 8) ? (t == 0) : (t != 8), 1'b0);
            step();
        end
        for (int t = 0; t < 3; t++) begin
            chk("D_full_irdy",  VW'(in_ready),  VW'(0));
            chk("D_full_level", VW'(level),     VW'(2));
            chk("D_full_ovld",  VW'(out_valid), VW'(1));
            chk("D_frozen",     out_vec,        vec(4, 1'b1, 0));
            drive(1'b1, vec(9, 1'b0, t), 1'b0, 1'b0, 1'b0);
            step();
        end
        for (int t = 0; t < 16; t++) begin
            chk("D_drain_ovld",  VW'(out_valid), VW'(1));
            chk("D_drain_level", VW'(level),     VW'((t < 8) ? 2 : 1));
            chk("D_drain_irdy",  VW'(in_ready),  VW'(t >= 8));
            chk("D_drain_vec", out_vec, (t < 8) ? vec(4, 1'b1, t) : vec(5, 1'b0, t - 8));
            drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
            step();
        end
        chk("D_end_ovld",  VW'(out_valid), VW'(0));
        chk("D_end_level", VW'(level),     VW'(0));

        // Clear after 5 rows (row on the clear cycle dropped), then a fresh block.
        for (int t = 0; t < 18; t++) begin
            chk("E_ovld",  VW'(out_valid), VW'(t >= 14));
            chk("E_level", VW'(level),     VW'(t >= 14));
            if (t >= 14) chk("E_vec", out_vec, vec(6, 1'b1, t - 14));
            if (t < 6)       drive(1'b1, vec(9, 1'b0, t), t == 5, 1'b1, 1'b1);
            else if (t < 14) drive(1'b1, vec(6, 1'b0, t - 6), 1'b0, 1'b1, 1'b1);
            else             drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
            if (t == 17) rst = 1'b0;
            step();
        end
        chk("E_rst_ovld",  VW'(out_valid), VW'(0));
        chk("E_rst_level", VW'(level),     VW'(0));
        chk("E_rst_irdy",  VW'(in_ready),  VW'(1));
        rst = 1'b1;

        // First block after reset comes out whole and alone.
        for (int t = 0; t < 17; t++) begin
            chk("F_ovld", VW'(out_valid), VW'(t >= 8 && t < 16));
            if (t >= 8 && t < 16) chk("F_vec", out_vec, vec(7, 1'b0, t - 8));
            drive(t < 8, (t < 8) ? vec(7, 1'b0, t) : '0, 1'b0, 1'b0, 1'b1);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/transpose_dbuf.md
TRANSPOSE_DBUF -- requirements
Module: transpose_dbuf

Interface
REQ-001 SHALL have parameter N, default 8, meaning block dimension (N x N elements, N >= 2).
REQ-002 SHALL have parameter W, default 12, meaning element width in bits.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  in_row holds a valid row.
REQ-006 SHALL have port in_ready  output  1  block can accept a row this cycle.
REQ-007 SHALL have port in_row  input  N*W  one row; element j at bits [(j+1)*W-1 : j*W].
REQ-008 SHALL have port in_clr  input  1  discard the partially written block.
REQ-009 SHALL have port mode  input  1  1 = transpose (column out), 0 = pass-through (row out).
REQ-010 SHALL have port out_valid  output  1  out_vec holds a valid vector.
REQ-011 SHALL have port out_ready  input  1  consumer accepts out_vec this cycle.
REQ-012 SHALL have port out_vec  output  N*W  output vector, same element packing as in_row.
REQ-013 SHALL have port level  output  2  number of complete blocks held (0..2).

Function
REQ-014 SHALL hold two N x N banks used ping-pong: writer fills bank wr_bank, reader drains bank rd_bank.
REQ-015 SHALL accept a row when in_valid and in_ready are both 1, storing it at row wr_cnt of wr_bank and incrementing wr_cnt.
REQ-016 SHALL drive in_ready = 1 exactly when bank wr_bank is not full.
REQ-017 SHALL latch mode into the bank on acceptance of row 0; mode changes mid-block do not affect that block.
REQ-018 SHALL, on acceptance of row N-1, mark the bank full, reset wr_cnt to 0 and toggle wr_bank.
REQ-019 SHALL drive out_valid = 1 exactly when bank rd_bank is full; first vector valid the cycle after row N-1 is accepted (latency 1).
REQ-020 SHALL output, for vector index k = rd_cnt: transpose mode, element r = bank[r][k]; pass-through mode, element c = bank[k][c].
REQ-021 SHALL hold out_vec stable while out_valid = 1 and out_ready = 0.
REQ-022 SHALL, on out_valid and out_ready, increment rd_cnt; on index N-1 mark the bank empty, reset rd_cnt to 0 and toggle rd_bank.
REQ-023 SHALL sustain one row in and one vector out per cycle with no bubbles when out_ready is held 1.
REQ-024 SHALL handle bank-fill and bank-release in the same cycle (different banks) with both taking effect; level unchanged.
REQ-025 SHALL, on in_clr = 1, reset wr_cnt to 0 without touching full banks or the reader; a row accepted in the same cycle is discarded.
REQ-026 SHALL ignore in_valid when in_ready = 0 and out_ready when out_valid = 0.
REQ-027 SHALL drive level as the count of full banks, updated in the same edge as the fill/release.

Reset
REQ-028 SHALL, while rst = 0, set wr_cnt = rd_cnt = 0, wr_bank = rd_bank = 0, both banks empty, out_valid = 0, in_ready = 1, level = 0.
REQ-029 SHALL not reset bank storage; out_vec is don't-care while out_valid = 0.
REQ-030 SHALL, on reset mid-block, discard all partial and full blocks; first vector after reset comes only from a block written entirely after reset.

Structure
REQ-031 SHALL take default N, W and the element typedef (logic [W-1:0]) from a shared package transpose_pkg.
REQ-032 SHALL instantiate one sub-module tbank (one N x N storage bank with row write port and row/column read mux), twice.

Verification (N=8, W=12)
REQ-033 SHALL cover: rows with element(r,c)=16r+c, mode=1, out_ready=1 -> vector 3 = {0x073,0x063,...,0x003} (element r = 16r+3), out_valid first high cycle 8.
REQ-034 SHALL cover: same block with mode=0 -> vector 3 = row 3 = elements 0x030..0x037.
REQ-035 SHALL cover: 16 rows back-to-back, out_ready=1 -> in_ready never drops, 16 vectors out in order, level never exceeds 1.
REQ-036 SHALL cover: out_ready=0 while 16 rows offered -> in_ready low after row 15, level=2, out_vec frozen; release -> both blocks drain correctly.
REQ-037 SHALL cover: in_clr after 5 rows, then 8 fresh rows -> only the fresh block appears; rst=0 mid-drain -> out_valid=0 next cycle, level=0, in_ready=1.
